// File: rtl/h80bus_arbiter.sv
// h80bus_arbiter: two-master round-robin arbiter and single-transaction sequencer
// for the h80 peripheral bus, with wait_n stretching and a bounded access timeout.
module h80bus_arbiter #(
   parameter int BUS_ADDR_WIDTH = 16,
   parameter int BUS_CMD_WIDTH  = 3,
   parameter int BUS_DATA_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      m0_req,
   input  logic [BUS_ADDR_WIDTH-1:0] m0_addr,
   input  logic [BUS_CMD_WIDTH-1:0]  m0_cmd,
   input  logic                      m0_wr,
   input  logic [BUS_DATA_WIDTH-1:0] m0_wdata,
   output logic [BUS_DATA_WIDTH-1:0] m0_rdata,
   output logic                      m0_ack,
   output logic                      m0_err,

   input  logic                      m1_req,
   input  logic [BUS_ADDR_WIDTH-1:0] m1_addr,
   input  logic [BUS_CMD_WIDTH-1:0]  m1_cmd,
   input  logic                      m1_wr,
   input  logic [BUS_DATA_WIDTH-1:0] m1_wdata,
   output logic [BUS_DATA_WIDTH-1:0] m1_rdata,
   output logic                      m1_ack,
   output logic                      m1_err,

   output logic                      bus_ce_n,
   output logic [BUS_ADDR_WIDTH-1:0] bus_addr,
   output logic [BUS_CMD_WIDTH-1:0]  bus_cmd,
   output logic [BUS_DATA_WIDTH-1:0] bus_wdata,
   output logic                      bus_oe,
   input  logic [BUS_DATA_WIDTH-1:0] bus_rdata,
   input  logic                      bus_wait_n
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam int CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t                    state;
   logic                      last_grant;
   logic                      cur_port;
   logic                      cur_wr;
   logic [CNT_W-1:0]          count;

   logic                      grant_valid;
   logic                      grant_port;
   logic [BUS_ADDR_WIDTH-1:0] sel_addr;
   logic [BUS_CMD_WIDTH-1:0]  sel_cmd;
   logic                      sel_wr;
   logic [BUS_DATA_WIDTH-1:0] sel_wdata;
   logic                      timeout_hit;

   // Round-robin pick: on a tie the port that did not win last time goes next.
   always_comb begin
      grant_valid = m0_req | m1_req;
      if (m0_req && m1_req) begin
         grant_port = ~last_grant;
      end else if (m1_req) begin
         grant_port = 1'b1;
      end else begin
         grant_port = 1'b0;
      end

      if (grant_port) begin
         sel_addr  = m1_addr;
         sel_cmd   = m1_cmd;
         sel_wr    = m1_wr;
         sel_wdata = m1_wdata;
      end else begin
         sel_addr  = m0_addr;
         sel_cmd   = m0_cmd;
         sel_wr    = m0_wr;
         sel_wdata = m0_wdata;
      end
   end

   // Timeout fires on the TIMEOUT_CYCLES-th ACCESS cycle, unless disabled.
   always_comb begin
      if (TIMEOUT_EN) begin
         timeout_hit = (count == CNT_LAST);
      end else begin
         timeout_hit = 1'b0;
      end
   end

   // Transaction sequencer: grant, hold the bus through wait/timeout, then turn around.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cur_port   <= 1'b0;
         cur_wr     <= 1'b0;
         count      <= {CNT_W{1'b0}};
         bus_ce_n   <= 1'b1;
         bus_oe     <= 1'b0;
         bus_addr   <= {BUS_ADDR_WIDTH{1'b0}};
         bus_cmd    <= {BUS_CMD_WIDTH{1'b0}};
         bus_wdata  <= {BUS_DATA_WIDTH{1'b0}};
         m0_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m0_rdata   <= {BUS_DATA_WIDTH{1'b0}};
         m1_ack     <= 1'b0;
         m1_err     <= 1'b0;
         m1_rdata   <= {BUS_DATA_WIDTH{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  bus_addr   <= sel_addr;
                  bus_cmd    <= sel_cmd;
                  bus_wdata  <= sel_wdata;
                  bus_oe     <= sel_wr;
                  bus_ce_n   <= 1'b0;
                  cur_wr     <= sel_wr;
                  cur_port   <= grant_port;
                  last_grant <= grant_port;
                  count      <= {CNT_W{1'b0}};
                  state      <= ACCESS;
               end else begin
                  state <= IDLE;
               end
            end

            ACCESS: begin
               if (bus_wait_n) begin
                  if (!cur_wr) begin
                     if (cur_port) begin
                        m1_rdata <= bus_rdata;
                     end else begin
                        m0_rdata <= bus_rdata;
                     end
                  end else begin
                     state <= ACCESS;
                  end
                  if (cur_port) begin
                     m1_ack <= 1'b1;
                     m1_err <= 1'b0;
                  end else begin
                     m0_ack <= 1'b1;
                     m0_err <= 1'b0;
                  end
                  bus_ce_n <= 1'b1;
                  bus_oe   <= 1'b0;
                  state    <= RELEASE;
               end else if (timeout_hit) begin
                  if (cur_port) begin
                     m1_ack   <= 1'b1;
                     m1_err   <= 1'b1;
                     m1_rdata <= {BUS_DATA_WIDTH{1'b1}};
                  end else begin
                     m0_ack   <= 1'b1;
                     m0_err   <= 1'b1;
                     m0_rdata <= {BUS_DATA_WIDTH{1'b1}};
                  end
                  bus_ce_n <= 1'b1;
                  bus_oe   <= 1'b0;
                  state    <= RELEASE;
               end else if (count != CNT_MAX) begin
                  count <= count + CNT_ONE;
               end else begin
                  count <= count;
               end
            end

            RELEASE: begin
               m0_ack <= 1'b0;
               m0_err <= 1'b0;
               m1_ack <= 1'b0;
               m1_err <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               bus_ce_n <= 1'b1;
               bus_oe   <= 1'b0;
               m0_ack   <= 1'b0;
               m0_err   <= 1'b0;
               m1_ack   <= 1'b0;
               m1_err   <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_h80bus_arbiter.sv
// Scoreboard bench for h80bus_arbiter: masters push expected responses per port,
// a negedge monitor pairs each ack with the observed bus transaction and compares.
module tb_h80bus_arbiter;

   localparam int AW = 16;
   localparam int CW = 3;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          m0_req, m0_wr, m0_ack, m0_err;
   logic [AW-1:0] m0_addr;
   logic [CW-1:0] m0_cmd;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_wr, m1_ack, m1_err;
   logic [AW-1:0] m1_addr;
   logic [CW-1:0] m1_cmd;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          bus_ce_n, bus_oe, bus_wait_n;
   logic [AW-1:0] bus_addr;
   logic [CW-1:0] bus_cmd;
   logic [DW-1:0] bus_wdata, bus_rdata;

   always #5 clk = ~clk;

   h80bus_arbiter #(
      .BUS_ADDR_WIDTH(AW), .BUS_CMD_WIDTH(CW), .BUS_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd), .m0_wr(m0_wr),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_cmd(m1_cmd), .m1_wr(m1_wr),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
      .bus_ce_n(bus_ce_n), .bus_addr(bus_addr), .bus_cmd(bus_cmd), .bus_wdata(bus_wdata),
      .bus_oe(bus_oe), .bus_rdata(bus_rdata), .bus_wait_n(bus_wait_n)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [CW-1:0] cmd;
      bit            wr;
      logic [DW-1:0] wdata;
      int            lowcyc;
      bit            err;
      logic [DW-1:0] rdata;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [CW-1:0] cmd;
      bit            oe;
      logic [DW-1:0] wdata;
      int            lowcyc;
      bit            stable;
   } bus_t;

   exp_t          exp_q0[$];
   exp_t          exp_q1[$];
   bus_t          bus_q[$];
   int            grant_q[$];
   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] model_rd[2];
   int            last_served;
   int            fixed_wait;
   bit            hang_all;
   int            bus_txn_cnt = 0;
   int            ack_cnt[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Slave behaviour: wait count from the low address bits (or a forced value),
   // hangs forever when the top nibble is F or hang_all is set.
   function automatic int slave_waits(input logic [AW-1:0] a);
      return (fixed_wait >= 0) ? fixed_wait : int'(a[2:0]);
   endfunction

   function automatic bit slave_hang(input logic [AW-1:0] a);
      return hang_all || (a[15:12] == 4'hF);
   endfunction

   function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
      return a ^ 16'h00A5;
   endfunction

   // Reference model: outcome of one transaction from the bus rules alone.
   task automatic make_exp(input int p, input logic [AW-1:0] a, input logic [CW-1:0] c,
                           input bit w, input logic [DW-1:0] d, output exp_t ex);
      bit timed;
      timed     = slave_hang(a) || (slave_waits(a) >= TO);
      ex.addr   = a;
      ex.cmd    = c;
      ex.wr     = w;
      ex.wdata  = d;
      ex.err    = timed;
      ex.lowcyc = timed ? TO : slave_waits(a) + 1;
      ex.rdata  = timed ? 16'hFFFF : (w ? model_rd[p] : slave_data(a));
      model_rd[p] = ex.rdata;
   endtask

   int scnt = 0;
   always @(negedge clk) begin
      if (reset || bus_ce_n) begin
         scnt       = 0;
         bus_wait_n = 1'b1;
         bus_rdata  = 16'($urandom);
      end else begin
         bus_wait_n = !slave_hang(bus_addr) && (scnt >= slave_waits(bus_addr));
         bus_rdata  = slave_data(bus_addr);
         scnt++;
      end
   end

   task automatic handle_ack(input int p, input logic e, input logic [DW-1:0] rd);
      exp_t ex;
      bus_t bt;
      ack_cnt[p]++;
      grant_q.push_back(p);
      if ((p == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
         check($sformatf("pending_txn_m%0d", p), 32'd0, 32'd1);
      end else if (bus_q.size() == 0) begin
         check($sformatf("bus_txn_seen_m%0d", p), 32'd0, 32'd1);
      end else begin
         ex = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         bt = bus_q.pop_front();
         check($sformatf("m%0d_err", p), 32'(e), 32'(ex.err));
         check($sformatf("m%0d_rdata", p), 32'(rd), 32'(ex.rdata));
         check($sformatf("m%0d_bus_addr", p), 32'(bt.addr), 32'(ex.addr));
         check($sformatf("m%0d_bus_cmd", p), 32'(bt.cmd), 32'(ex.cmd));
         check($sformatf("m%0d_bus_oe", p), 32'(bt.oe), 32'(ex.wr));
         check($sformatf("m%0d_bus_wdata", p), 32'(bt.wdata), 32'(ex.wdata));
         check($sformatf("m%0d_ce_low_cycles", p), 32'(bt.lowcyc), 32'(ex.lowcyc));
         check($sformatf("m%0d_bus_stable", p), 32'(bt.stable), 32'd1);
      end
   endtask

   bit   prev_ce = 1'b1;
   int   gap = 100;
   bus_t cur;
   bit   prev_ack[2];

   always @(negedge clk) begin
      if (reset) begin
         prev_ce = 1'b1;
         gap     = 100;
         bus_q.delete();
         prev_ack[0] = 1'b0;
         prev_ack[1] = 1'b0;
      end else begin
         if (!bus_ce_n) begin
            if (prev_ce) begin
               check("turnaround_high_cycles", (gap < 2) ? gap : 2, 32'd2);
               cur.addr = bus_addr; cur.cmd = bus_cmd; cur.oe = bus_oe;
               cur.wdata = bus_wdata; cur.lowcyc = 1; cur.stable = 1'b1;
            end else begin
               cur.lowcyc++;
               if (bus_addr !== cur.addr || bus_cmd !== cur.cmd ||
                   bus_wdata !== cur.wdata || bus_oe !== cur.oe) cur.stable = 1'b0;
            end
         end else begin
            if (!prev_ce) begin
               check("oe_after_release", 32'(bus_oe), 32'd0);
               bus_q.push_back(cur);
               bus_txn_cnt++;
               gap = 0;
            end
            gap++;
         end
         prev_ce = bus_ce_n;

         for (int p = 0; p < 2; p++) begin
            logic a, e;
            a = (p == 0) ? m0_ack : m1_ack;
            e = (p == 0) ? m0_err : m1_err;
            if (a && prev_ack[p]) check($sformatf("m%0d_ack_one_cycle", p), 32'd2, 32'd1);
            if (e && !a) check($sformatf("m%0d_err_needs_ack", p), 32'(a), 32'd1);
            if (a && !prev_ack[p]) handle_ack(p, e, (p == 0) ? m0_rdata : m1_rdata);
            prev_ack[p] = a;
         end
         if (m0_ack && m1_ack) check("dual_ack", 32'd1, 32'd0);
      end
   end

   // Master behaviour: push expectation, raise req, drop it on seeing ack.
   task automatic do_txn(input int p, input logic [AW-1:0] a, input logic [CW-1:0] c,
                         input bit w, input logic [DW-1:0] d, input bit chk_lat);
      exp_t ex;
      int   lat;
      bit   got;
      make_exp(p, a, c, w, d, ex);
      if (p == 0) begin
         exp_q0.push_back(ex);
         m0_addr = a; m0_cmd = c; m0_wr = w; m0_wdata = d; m0_req = 1'b1;
      end else begin
         exp_q1.push_back(ex);
         m1_addr = a; m1_cmd = c; m1_wr = w; m1_wdata = d; m1_req = 1'b1;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 200) begin
         @(negedge clk);
         lat++;
         got = (p == 0) ? m0_ack : m1_ack;
      end
      if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
      if (!got) check($sformatf("m%0d_ack_within_bound", p), 32'd0, 32'd1);
      else if (chk_lat) check($sformatf("m%0d_ack_latency", p), 32'(lat), 32'(ex.lowcyc + 1));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      int n0, nb;
      reset = 1'b1;
      m0_req = 1'b0; m0_addr = '0; m0_cmd = '0; m0_wr = 1'b0; m0_wdata = '0;
      m1_req = 1'b0; m1_addr = '0; m1_cmd = '0; m1_wr = 1'b0; m1_wdata = '0;
      fixed_wait = -1; hang_all = 1'b0;
      model_rd[0] = '0; model_rd[1] = '0; last_served = 1;
      ack_cnt[0] = 0; ack_cnt[1] = 0;
      repeat (3) @(negedge clk);
      check("rst_ce_n", 32'(bus_ce_n), 32'd1);
      check("rst_oe", 32'(bus_oe), 32'd0);
      check("rst_addr", 32'(bus_addr), 32'd0);
      check("rst_cmd", 32'(bus_cmd), 32'd0);
      check("rst_wdata", 32'(bus_wdata), 32'd0);
      check("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
      check("rst_errs", {30'd0, m1_err, m0_err}, 32'd0);
      check("rst_m0_rdata", 32'(m0_rdata), 32'd0);
      check("rst_m1_rdata", 32'(m1_rdata), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      do_txn(0, 16'h0000, 3'd2, 1'b0, 16'h1234, 1'b1);
      last_served = 0;
      @(negedge clk);
      fixed_wait = 3;
      do_txn(1, 16'h0000, 3'd5, 1'b1, 16'h0041, 1'b1);
      fixed_wait = -1;
      last_served = 1;
      @(negedge clk);

      grant_q.delete();
      w = 1 - last_served;
      fork
         begin
            for (int i = 0; i < 2; i++) begin
               do_txn(0, 16'h1230 + 16'(i), 3'd1, i[0], 16'hA000 + 16'(i), 1'b0);
               @(negedge clk);
            end
         end
         begin
            for (int j = 0; j < 2; j++) begin
               do_txn(1, 16'h4562 + 16'(j), 3'd6, ~j[0], 16'hB000 + 16'(j), 1'b0);
               @(negedge clk);
            end
         end
      join
      check("rr_grant_count", 32'(grant_q.size()), 32'd4);
      for (int k = 0; k < 4 && k < grant_q.size(); k++)
         check($sformatf("rr_grant_%0d", k), 32'(grant_q[k]), 32'((k % 2 == 0) ? w : 1 - w));
      last_served = 1 - w;

      hang_all = 1'b1;
      do_txn(0, 16'h0040, 3'd3, 1'b0, 16'h0000, 1'b1);
      hang_all = 1'b0;
      @(negedge clk);
      do_txn(1, 16'h0042, 3'd3, 1'b0, 16'h0000, 1'b1);
      @(negedge clk);
      do_txn(0, 16'h0047, 3'd4, 1'b0, 16'h0000, 1'b1);
      @(negedge clk);

      fixed_wait = 6;
      m0_addr = 16'h0100; m0_cmd = 3'd7; m0_wr = 1'b1; m0_wdata = 16'h5555; m0_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_rst_ce_n", 32'(bus_ce_n), 32'd1);
      check("async_rst_oe", 32'(bus_oe), 32'd0);
      check("async_rst_addr", 32'(bus_addr), 32'd0);
      check("async_rst_m0_ack", 32'(m0_ack), 32'd0);
      check("async_rst_m0_rdata", 32'(m0_rdata), 32'd0);
      m0_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      fixed_wait = -1;
      model_rd[0] = '0; model_rd[1] = '0; last_served = 1;
      @(negedge clk);

      grant_q.delete();
      fork
         do_txn(0, 16'h0201, 3'd1, 1'b1, 16'hC0DE, 1'b0);
         do_txn(1, 16'h0302, 3'd2, 1'b0, 16'h0000, 1'b0);
      join
      check("post_rst_tie_winner", (grant_q.size() > 0) ? 32'(grant_q[0]) : 32'd9,
            32'(1 - last_served));
      last_served = 1;
      @(negedge clk);

      fixed_wait = 3;
      n0 = ack_cnt[0];
      nb = bus_txn_cnt;
      fork
         do_txn(1, 16'h2000, 3'd0, 1'b0, 16'h0000, 1'b1);
         begin
            @(negedge clk);
            @(negedge clk);
            m0_addr = 16'h3000; m0_wr = 1'b0; m0_req = 1'b1;
            @(negedge clk);
            m0_req = 1'b0;
         end
      join
      repeat (4) @(negedge clk);
      check("withdrawn_m0_acks", 32'(ack_cnt[0] - n0), 32'd0);
      check("withdrawn_bus_txns", 32'(bus_txn_cnt - nb), 32'd1);
      fixed_wait = -1;

      fork
         begin
            for (int i = 0; i < 15; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               do_txn(0, 16'($urandom), 3'($urandom), 1'($urandom), 16'($urandom), 1'b0);
               @(negedge clk);
            end
         end
         begin
            for (int j = 0; j < 15; j++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               do_txn(1, 16'($urandom), 3'($urandom), 1'($urandom), 16'($urandom), 1'b0);
               @(negedge clk);
            end
         end
      join
      repeat (5) @(negedge clk);
      check("m0_queue_drained", 32'(exp_q0.size()), 32'd0);
      check("m1_queue_drained", 32'(exp_q1.size()), 32'd0);
      check("bus_queue_drained", 32'(bus_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
